// File: rtl/led_pwm_fader_pkg.sv
// Shared defaults and types for the LED PWM fader: channel count, brightness
// resolution and the level type used by the channels.
package led_pkg;

   localparam int DEF_LED_COUNT = 8;
   localparam int DEF_PWM_BITS  = 4;

   typedef logic [DEF_PWM_BITS-1:0] level_t;

   localparam level_t PWM_MAX = level_t'((1 << DEF_PWM_BITS) - 1);

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: holds the current brightness level, steps it toward the
// target on fade ticks (or snaps when fading is off), and compares it to the PWM phase.
module led_fade_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS = DEF_PWM_BITS
) (
   input  logic                clk100khz,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] target,
   input  logic                tick,
   input  logic                fade_en,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led,
   output logic                neq
);

   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] level_next;

   // NOTE: default assignment first so every path assigns level_next; no latch.
   always_comb begin
      level_next = level;
      if (!fade_en) begin
         level_next = target;
      end else if (tick) begin
         if (level < target)      level_next = level + 1'b1;
         else if (level > target) level_next = level - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
   always_ff @(posedge clk100khz) begin
      if (rst) level <= '0;
      else     level <= level_next;
   end

   assign led = (level > pwm_cnt);
   // Compared on the post-update level so busy clears on the edge the ramp lands.
   assign neq = (level_next != target);

endmodule

// File: rtl/led_pwm_fader.sv
// PWM brightness stage with optional per-LED fading between off and the
// programmed brightness; sits between the pattern generator and the LED pins.
module led_pwm_fader
   import led_pkg::*;
#(
   parameter int LED_COUNT = DEF_LED_COUNT,
   parameter int PWM_BITS  = DEF_PWM_BITS,
   parameter int STEP_DIV  = 625
) (
   input  logic                 clk100khz,
   input  logic                 rst,
   input  logic [LED_COUNT-1:0] light_in,
   input  logic [PWM_BITS-1:0]  brightness,
   input  logic                 fade_en,
   output logic [LED_COUNT-1:0] led_out,
   output logic                 busy
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
   // PWM period is 2^PWM_BITS-1 so the top level can be fully on.
   localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

   logic [LED_COUNT-1:0] light_q;
   logic [LED_COUNT-1:0] led_bit;
   logic [LED_COUNT-1:0] neq;
   logic [PWM_BITS-1:0]  pwm_cnt;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk100khz) begin
      if (rst) begin
         light_q <= '0;
         pwm_cnt <= '0;
         div_cnt <= '0;
         led_out <= '0;
         busy    <= 1'b0;
      end else begin
         light_q <= light_in;
         pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         led_out <= led_bit;
         busy    <= |neq;
      end
   end

   for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
      logic [PWM_BITS-1:0] target;
      assign target = light_q[i] ? brightness : '0;

      led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
         .clk100khz (clk100khz),
         .rst       (rst),
         .target    (target),
         .tick      (tick),
         .fade_en   (fade_en),
         .pwm_cnt   (pwm_cnt),
         .led       (led_bit[i]),
         .neq       (neq[i])
      );
   end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: a cycle-level reference model queues the
// expected led_out/busy per edge and a monitor compares them half a cycle later.
module tb_led_pwm_fader;
   import led_pkg::*;

   localparam int N      = DEF_LED_COUNT;
   localparam int SD     = 4;
   localparam int PERIOD = int'(PWM_MAX);

   logic          clk100khz = 1'b0;
   logic          rst       = 1'b1;
   logic [N-1:0]  light_in  = '0;
   level_t        brightness = '0;
   logic          fade_en   = 1'b0;
   logic [N-1:0]  led_out;
   logic          busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [N-1:0] led;
      logic         busy;
   } exp_t;

   exp_t sb[$];

   // Reference state: levels, registered pattern and cycles since reset.
   level_t       m_level[N];
   logic [N-1:0] m_light;
   int           cyc;

   always #5 clk100khz = ~clk100khz;

   led_pwm_fader #(.LED_COUNT(N), .PWM_BITS(DEF_PWM_BITS), .STEP_DIV(SD)) dut (
      .clk100khz  (clk100khz),
      .rst        (rst),
      .light_in   (light_in),
      .brightness (brightness),
      .fade_en    (fade_en),
      .led_out    (led_out),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      exp_t   e;
      level_t tgt;
      logic   tick;
      e = '0;
      if (rst) begin
         for (int i = 0; i < N; i++) m_level[i] = '0;
         m_light = '0;
         cyc     = 0;
      end else begin
         tick = ((cyc % SD) == SD - 1);
         for (int i = 0; i < N; i++) begin
            e.led[i] = (int'(m_level[i]) > (cyc % PERIOD));
            tgt = m_light[i] ? brightness : level_t'(0);
            if (!fade_en)                    m_level[i] = tgt;
            else if (tick && m_level[i] < tgt) m_level[i] = m_level[i] + 1'b1;
            else if (tick && m_level[i] > tgt) m_level[i] = m_level[i] - 1'b1;
            if (m_level[i] != tgt) e.busy = 1'b1;
         end
         m_light = light_in;
         cyc++;
      end
      sb.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk100khz);
         model_step();
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk100khz);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_led", 32'(led_out), 32'(e.led));
            check("sb_busy", 32'(busy), 32'(e.busy));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk100khz);
      #1;
   endtask

   // Advance until the model's channel-0 level equals lvl; false on timeout.
   task automatic wait_level(input level_t lvl, input int budget, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (m_level[0] == lvl) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
   endtask

   task automatic wait_idle(input int budget, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (busy == 1'b0) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
   endtask

   task automatic settle_off();
      fade_en  = 1'b0;
      light_in = '0;
      step(4);
   endtask

   initial begin
      logic ok;
      int   highs;

      // Reset held with all lights requested at full brightness.
      rst = 1'b1; light_in = 8'hFF; brightness = 4'd15; fade_en = 1'b0;
      step(3);
      rst = 1'b0;
      step(1);
      check("rst_release_led", 32'(led_out), 32'h0);
      check("rst_release_busy", 32'(busy), 32'h0);

      // Snap mode, full brightness: pattern passes through unchanged.
      light_in = 8'hA5;
      step(3);
      for (int k = 0; k < PERIOD; k++) begin
         check("snap_full_led", 32'(led_out), 32'hA5);
         step(1);
      end

      // Snap mode, brightness 4 on LED 0 only.
      brightness = 4'd4; light_in = 8'h01;
      step(3);
      highs = 0;
      for (int k = 0; k < PERIOD; k++) begin
         highs += int'(led_out[0]);
         check("duty4_others_off", 32'(led_out[N-1:1]), 32'h0);
         step(1);
      end
      check("duty4_high_cycles", 32'(highs), 32'd4);

      // Fade up from dark to full.
      brightness = 4'd15;
      settle_off();
      fade_en = 1'b1; light_in = 8'hFF;
      step(2);
      check("fade_up_busy", 32'(busy), 32'h1);
      wait_idle(16 * SD + 8, ok);
      check("fade_up_done", 32'(ok), 32'h1);
      for (int k = 0; k < PERIOD; k++) begin
         check("fade_up_full", 32'(led_out), 32'hFF);
         step(1);
      end

      // Reverse mid-ramp at level 8.
      settle_off();
      fade_en = 1'b1; light_in = 8'hFF;
      wait_level(level_t'(8), 16 * SD, ok);
      check("reverse_reached8", 32'(ok), 32'h1);
      light_in = 8'h00;
      step(2);
      check("reverse_busy", 32'(busy), 32'h1);
      wait_idle(16 * SD + 8, ok);
      check("reverse_done", 32'(ok), 32'h1);
      check("reverse_dark", 32'(led_out), 32'h0);

      // Reset in the middle of a ramp at level 6.
      light_in = 8'hFF;
      wait_level(level_t'(6), 16 * SD, ok);
      check("midrst_reached6", 32'(ok), 32'h1);
      rst = 1'b1;
      step(1);
      check("midrst_led", 32'(led_out), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      step(2);
      check("midrst_restart_busy", 32'(busy), 32'h1);
      wait_idle(16 * SD + 8, ok);
      check("midrst_restart_done", 32'(ok), 32'h1);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 7) == 0)   light_in   = N'($urandom);
         if ($urandom_range(0, 15) == 0)  brightness = level_t'($urandom);
         if ($urandom_range(0, 40) == 0)  fade_en    = ~fade_en;
         rst = ($urandom_range(0, 150) == 0);
         step(1);
      end
      rst = 1'b0;
      step(2);
      @(negedge clk100khz);
      #1;
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
